// File: rtl/cache_array_pkg.sv
// cache_array_pkg: shared state type, default geometry and
// packed-bus helper for the N-way cache storage array.
package cache_array_pkg;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_e;

    localparam int DEF_NUM_WAYS = 2;
    localparam int DEF_NUM_SETS = 256;
    localparam int DEF_TAG_W    = 19;
    localparam int DEF_LINE_W   = 512;

    // Low bit index of way w inside a packed per-way bus
    function automatic int way_lo(input int w, input int width);
        return w * width;
    endfunction

endpackage

// File: rtl/cache_way_ram.sv
// cache_way_ram: one way of tag + line storage, 1R1W,
// byte-enabled line write, registered read of stored contents.
module cache_way_ram #(
    parameter int NUM_SETS = 256,
    parameter int TAG_W    = 19,
    parameter int LINE_W   = 512,
    localparam int IDX_W   = $clog2(NUM_SETS),
    localparam int BE_W    = LINE_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rden,
    input  logic [IDX_W-1:0]  i_raddr,
    input  logic              i_wren,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [TAG_W-1:0]  i_wtag,
    input  logic [LINE_W-1:0] i_wdata,
    input  logic [BE_W-1:0]   i_wbe,
    output logic [TAG_W-1:0]  o_rtag,
    output logic [LINE_W-1:0] o_rdata
);

    logic [TAG_W-1:0]  r_tag_mem  [NUM_SETS];
    logic [LINE_W-1:0] r_data_mem [NUM_SETS];
    logic [TAG_W-1:0]  r_rtag;
    logic [LINE_W-1:0] r_rdata;

    // Storage write: tag always, line only on enabled bytes
    always_ff @(posedge clk) begin
        if (i_wren) begin
            r_tag_mem[i_waddr] <= i_wtag;
            for (int b = 0; b < BE_W; b++) begin
                if (i_wbe[b]) begin
                    r_data_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered read; holds last value when no read issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rtag  <= '0;
            r_rdata <= '0;
        end else if (i_rden) begin
            r_rtag  <= r_tag_mem[i_raddr];
            r_rdata <= r_data_mem[i_raddr];
        end
    end

    assign o_rtag  = r_rtag;
    assign o_rdata = r_rdata;

endmodule

// File: rtl/cache_way_array.sv
// cache_way_array: N-way cache storage with valid/dirty flops,
// invalidate sweep FSM and write-first read bypass.
module cache_way_array
    import cache_array_pkg::*;
#(
    parameter int NUM_WAYS = DEF_NUM_WAYS,
    parameter int NUM_SETS = DEF_NUM_SETS,
    parameter int TAG_W    = DEF_TAG_W,
    parameter int LINE_W   = DEF_LINE_W,
    localparam int IDX_W   = $clog2(NUM_SETS),
    localparam int WAY_W   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int BE_W    = LINE_W / 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       inv_all_i,
    output logic                       busy_o,
    input  logic                       rden_i,
    input  logic [IDX_W-1:0]           raddr_i,
    output logic                       rvalid_o,
    output logic [NUM_WAYS*TAG_W-1:0]  rdata_tag_o,
    output logic [NUM_WAYS-1:0]        rdata_valid_o,
    output logic [NUM_WAYS-1:0]        rdata_dirty_o,
    output logic [NUM_WAYS*LINE_W-1:0] rdata_data_o,
    input  logic                       wren_i,
    input  logic [IDX_W-1:0]           waddr_i,
    input  logic [WAY_W-1:0]           wway_i,
    input  logic [TAG_W-1:0]           wdata_tag_i,
    input  logic                       wdata_valid_i,
    input  logic                       wdata_dirty_i,
    input  logic [LINE_W-1:0]          wdata_data_i,
    input  logic [BE_W-1:0]            wbyte_en_i
);

    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);

    state_e             r_state;
    logic [IDX_W-1:0]   r_cnt;
    logic               r_busy;

    logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
    logic [NUM_WAYS-1:0] r_dirty [NUM_SETS];

    logic                r_rvalid;
    logic [NUM_WAYS-1:0] r_rd_valid;
    logic [NUM_WAYS-1:0] r_rd_dirty;
    logic [NUM_WAYS-1:0] r_byp;
    logic [TAG_W-1:0]    r_byp_tag;
    logic [LINE_W-1:0]   r_byp_data;
    logic [BE_W-1:0]     r_byp_be;

    logic                w_idle;
    logic                w_rd_acc;
    logic                w_wr_acc;
    logic [NUM_WAYS-1:0] w_wr_way;
    logic [NUM_WAYS-1:0] w_byp;
    logic [TAG_W-1:0]    w_ram_tag  [NUM_WAYS];
    logic [LINE_W-1:0]   w_ram_data [NUM_WAYS];

    // Requests are taken only in IDLE; inv_all_i wins over both
    assign w_idle   = (r_state == IDLE);
    assign w_rd_acc = w_idle && rden_i && !inv_all_i;
    assign w_wr_acc = w_idle && wren_i && !inv_all_i;

    // Per-way write select and same-set read bypass detect
    always_comb begin
        w_wr_way = '0;
        w_byp    = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            w_wr_way[w] = w_wr_acc && (int'(wway_i) == w);
            w_byp[w]    = w_rd_acc && w_wr_way[w] &&
                          (raddr_i == waddr_i);
        end
    end

    // Sweep/idle control with registered busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SWEEP;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            unique case (r_state)
                SWEEP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_SET) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (inv_all_i) begin
                        r_state <= SWEEP;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Valid/dirty metadata: cleared by the sweep, not by reset
    always_ff @(posedge clk) begin
        if (r_state == SWEEP) begin
            r_valid[r_cnt] <= '0;
            r_dirty[r_cnt] <= '0;
        end else begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (w_wr_way[w]) begin
                    r_valid[waddr_i][w] <= wdata_valid_i;
                    r_dirty[waddr_i][w] <= wdata_dirty_i;
                end
            end
        end
    end

    // Read pipeline stage: metadata capture and bypass context
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid   <= 1'b0;
            r_rd_valid <= '0;
            r_rd_dirty <= '0;
            r_byp      <= '0;
            r_byp_tag  <= '0;
            r_byp_data <= '0;
            r_byp_be   <= '0;
        end else begin
            r_rvalid <= w_rd_acc;
            if (w_rd_acc) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    r_rd_valid[w] <= w_byp[w] ? wdata_valid_i
                                              : r_valid[raddr_i][w];
                    r_rd_dirty[w] <= w_byp[w] ? wdata_dirty_i
                                              : r_dirty[raddr_i][w];
                end
                r_byp      <= w_byp;
                r_byp_tag  <= wdata_tag_i;
                r_byp_data <= wdata_data_i;
                r_byp_be   <= wbyte_en_i;
            end
        end
    end

    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
        cache_way_ram #(
            .NUM_SETS (NUM_SETS),
            .TAG_W    (TAG_W),
            .LINE_W   (LINE_W)
        ) u_ram (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_rden  (w_rd_acc),
            .i_raddr (raddr_i),
            .i_wren  (w_wr_way[g]),
            .i_waddr (waddr_i),
            .i_wtag  (wdata_tag_i),
            .i_wdata (wdata_data_i),
            .i_wbe   (wbyte_en_i),
            .o_rtag  (w_ram_tag[g]),
            .o_rdata (w_ram_data[g])
        );
    end

    // Write-first merge of the bypassed way over stored contents
    always_comb begin
        rdata_tag_o  = '0;
        rdata_data_o = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            rdata_tag_o[way_lo(w, TAG_W) +: TAG_W] =
                r_byp[w] ? r_byp_tag : w_ram_tag[w];
            for (int b = 0; b < BE_W; b++) begin
                rdata_data_o[way_lo(w, LINE_W) + 8*b +: 8] =
                    (r_byp[w] && r_byp_be[b]) ? r_byp_data[8*b +: 8]
                                              : w_ram_data[w][8*b +: 8];
            end
        end
    end

    assign busy_o        = r_busy;
    assign rvalid_o      = r_rvalid;
    assign rdata_valid_o = r_rd_valid;
    assign rdata_dirty_o = r_rd_dirty;

endmodule

// File: tb/tb_cache_way_array.sv
// tb_cache_way_array: randomized self-checking bench with an
// array-based reference model of the cache storage.
module tb_cache_way_array;

    localparam int NW = 2;
    localparam int NS = 256;
    localparam int TW = 19;
    localparam int LW = 512;
    localparam int BW = LW / 8;

    logic              clk;
    logic              rst_n;
    logic              inv_all_i;
    logic              busy_o;
    logic              rden_i;
    logic [7:0]        raddr_i;
    logic              rvalid_o;
    logic [NW*TW-1:0]  rdata_tag_o;
    logic [NW-1:0]     rdata_valid_o;
    logic [NW-1:0]     rdata_dirty_o;
    logic [NW*LW-1:0]  rdata_data_o;
    logic              wren_i;
    logic [7:0]        waddr_i;
    logic [0:0]        wway_i;
    logic [TW-1:0]     wdata_tag_i;
    logic              wdata_valid_i;
    logic              wdata_dirty_i;
    logic [LW-1:0]     wdata_data_i;
    logic [BW-1:0]     wbyte_en_i;

    int checks = 0;
    int errors = 0;

    logic [TW-1:0] m_tag  [NW][NS];
    bit            m_val  [NW][NS];
    bit            m_dty  [NW][NS];
    logic [LW-1:0] m_data [NW][NS];

    logic [NW*TW-1:0] e_tag;
    logic [NW-1:0]    e_val;
    logic [NW-1:0]    e_dty;
    logic [NW*LW-1:0] e_data;

    cache_way_array dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inv_all_i     (inv_all_i),
        .busy_o        (busy_o),
        .rden_i        (rden_i),
        .raddr_i       (raddr_i),
        .rvalid_o      (rvalid_o),
        .rdata_tag_o   (rdata_tag_o),
        .rdata_valid_o (rdata_valid_o),
        .rdata_dirty_o (rdata_dirty_o),
        .rdata_data_o  (rdata_data_o),
        .wren_i        (wren_i),
        .waddr_i       (waddr_i),
        .wway_i        (wway_i),
        .wdata_tag_i   (wdata_tag_i),
        .wdata_valid_i (wdata_valid_i),
        .wdata_dirty_i (wdata_dirty_i),
        .wdata_data_i  (wdata_data_i),
        .wbyte_en_i    (wbyte_en_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void model_write(input int s, input int w,
                                        input logic [TW-1:0] t,
                                        input bit v, input bit d,
                                        input logic [LW-1:0] dat,
                                        input logic [BW-1:0] be);
        m_tag[w][s] = t;
        m_val[w][s] = v;
        m_dty[w][s] = d;
        for (int b = 0; b < BW; b++)
            if (be[b]) m_data[w][s][8*b +: 8] = dat[8*b +: 8];
    endfunction

    function automatic void model_clear_vd();
        for (int w = 0; w < NW; w++)
            for (int s = 0; s < NS; s++) begin
                m_val[w][s] = 1'b0;
                m_dty[w][s] = 1'b0;
            end
    endfunction

    function automatic void expect_set(input int s);
        for (int w = 0; w < NW; w++) begin
            e_tag[TW*w +: TW]  = m_tag[w][s];
            e_val[w]           = m_val[w][s];
            e_dty[w]           = m_dty[w][s];
            e_data[LW*w +: LW] = m_data[w][s];
        end
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic int first_diff(input logic [NW*LW-1:0] a,
                                      input logic [NW*LW-1:0] b);
        for (int i = 0; i < NW * LW / 64; i++)
            if (a[64*i +: 64] !== b[64*i +: 64]) return i;
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        inv_all_i     = 1'b0;
        rden_i        = 1'b0;
        raddr_i       = '0;
        wren_i        = 1'b0;
        waddr_i       = '0;
        wway_i        = '0;
        wdata_tag_i   = '0;
        wdata_valid_i = 1'b0;
        wdata_dirty_i = 1'b0;
        wdata_data_i  = '0;
        wbyte_en_i    = '0;
    endtask

    task automatic drive_write(input int s, input int w,
                               input logic [TW-1:0] t,
                               input bit v, input bit d,
                               input logic [LW-1:0] dat,
                               input logic [BW-1:0] be);
        wren_i        = 1'b1;
        waddr_i       = 8'(s);
        wway_i        = 1'(w);
        wdata_tag_i   = t;
        wdata_valid_i = v;
        wdata_dirty_i = d;
        wdata_data_i  = dat;
        wbyte_en_i    = be;
    endtask

    task automatic test_reset();
        int n;
        bit seen;
        idle_in();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy_o !== 1'b1 || rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl busy=%b rvalid=%b exp 1 0",
                     busy_o, rvalid_o);
        end
        checks++;
        if (rdata_tag_o !== '0 || rdata_valid_o !== '0 ||
            rdata_dirty_o !== '0 || rdata_data_o !== '0) begin
            errors++;
            $display("FAIL reset_rdata tag=%h v=%b d=%b exp zero",
                     rdata_tag_o, rdata_valid_o, rdata_dirty_o);
        end
        rden_i  = 1'b1;
        raddr_i = 8'h00;
        rst_n   = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (busy_o === 1'b1 && n < 1000) begin
            step();
            n++;
            if (rvalid_o !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL reset_busy_len got %0d exp 256", n);
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL busy_read_drop rvalid=1 exp 0");
        end
        model_clear_vd();
        raddr_i = 8'hFF;
        step();
        rden_i = 1'b0;
        checks++;
        if (rvalid_o !== 1'b1 || rdata_valid_o !== 2'b00 ||
            rdata_dirty_o !== 2'b00) begin
            errors++;
            $display("FAIL post_sweep_ff rv=%b v=%b d=%b exp 1 00 00",
                     rvalid_o, rdata_valid_o, rdata_dirty_o);
        end
    endtask

    task automatic test_fill();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) begin
                logic [TW-1:0] t;
                logic [LW-1:0] d;
                bit v, dt;
                t  = TW'($urandom);
                d  = rand_line();
                v  = 1'($urandom);
                dt = 1'($urandom);
                drive_write(s, w, t, v, dt, d, '1);
                model_write(s, w, t, v, dt, d, '1);
                step();
            end
        idle_in();
    endtask

    task automatic test_inv();
        int n;
        int k;
        int sets [4];
        sets = '{8'h20, 8'h3A, 8'h00, 8'hFF};
        drive_write(8'h20, 1, ~m_tag[1][8'h20], 1'b1, 1'b1,
                    ~m_data[1][8'h20], '1);
        rden_i    = 1'b1;
        raddr_i   = 8'h20;
        inv_all_i = 1'b1;
        step();
        idle_in();
        checks++;
        if (busy_o !== 1'b1 || rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL inv_prio busy=%b rvalid=%b exp 1 0",
                     busy_o, rvalid_o);
        end
        n = 0;
        while (busy_o === 1'b1 && n < 1000) begin
            inv_all_i = (n == 50);
            step();
            n++;
        end
        inv_all_i = 1'b0;
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL inv_busy_len got %0d exp 256", n);
        end
        model_clear_vd();
        foreach (sets[i]) begin
            rden_i  = 1'b1;
            raddr_i = 8'(sets[i]);
            expect_set(sets[i]);
            step();
            rden_i = 1'b0;
            checks++;
            if ({rvalid_o, rdata_tag_o, rdata_valid_o, rdata_dirty_o}
                !== {1'b1, e_tag, e_val, e_dty}) begin
                errors++;
                $display("FAIL inv_meta set=%h tag=%h v=%b d=%b exp %h %b %b",
                         sets[i], rdata_tag_o, rdata_valid_o,
                         rdata_dirty_o, e_tag, e_val, e_dty);
            end
            checks++;
            if (rdata_data_o !== e_data) begin
                errors++;
                k = first_diff(rdata_data_o, e_data);
                $display("FAIL inv_data set=%h chunk%0d got=%h exp=%h",
                         sets[i], k, rdata_data_o[64*k +: 64],
                         e_data[64*k +: 64]);
            end
        end
    endtask

    task automatic test_write_read();
        int k;
        drive_write(8'h3A, 1, 19'h5A5A5, 1'b1, 1'b0, {BW{8'h11}}, '1);
        model_write(8'h3A, 1, 19'h5A5A5, 1'b1, 1'b0, {BW{8'h11}}, '1);
        step();
        idle_in();
        rden_i  = 1'b1;
        raddr_i = 8'h3A;
        expect_set(8'h3A);
        step();
        rden_i = 1'b0;
        checks++;
        if (rvalid_o !== 1'b1 || rdata_tag_o[2*TW-1:TW] !== 19'h5A5A5 ||
            rdata_valid_o !== 2'b10) begin
            errors++;
            $display("FAIL wr_rd rv=%b tag1=%h v=%b exp 1 5a5a5 10",
                     rvalid_o, rdata_tag_o[2*TW-1:TW], rdata_valid_o);
        end
        checks++;
        if (rdata_data_o[2*LW-1:LW] !== {BW{8'h11}}) begin
            errors++;
            $display("FAIL wr_rd_data1 low=%h exp all 11",
                     rdata_data_o[LW +: 64]);
        end
        checks++;
        if (rdata_data_o !== e_data || rdata_tag_o !== e_tag) begin
            errors++;
            k = first_diff(rdata_data_o, e_data);
            $display("FAIL wr_rd_model chunk%0d got=%h exp=%h tag=%h exp=%h",
                     k, rdata_data_o[64*k +: 64], e_data[64*k +: 64],
                     rdata_tag_o, e_tag);
        end
        step();
        checks++;
        if (rvalid_o !== 1'b0 || rdata_data_o !== e_data ||
            rdata_tag_o !== e_tag) begin
            errors++;
            $display("FAIL rd_hold rv=%b tag=%h exp 0 %h",
                     rvalid_o, rdata_tag_o, e_tag);
        end
    endtask

    task automatic test_partial();
        drive_write(8'h3A, 1, 19'h5A5A5, 1'b1, 1'b1, {BW{8'hFF}},
                    64'h1);
        model_write(8'h3A, 1, 19'h5A5A5, 1'b1, 1'b1, {BW{8'hFF}},
                    64'h1);
        step();
        idle_in();
        rden_i  = 1'b1;
        raddr_i = 8'h3A;
        expect_set(8'h3A);
        step();
        rden_i = 1'b0;
        checks++;
        if (rdata_data_o[LW +: 8] !== 8'hFF ||
            rdata_data_o[2*LW-1:LW+8] !== {(BW-1){8'h11}}) begin
            errors++;
            $display("FAIL partial_be low=%h exp ..1111ff",
                     rdata_data_o[LW +: 64]);
        end
        checks++;
        if (rdata_dirty_o !== 2'b10 || rdata_data_o !== e_data) begin
            errors++;
            $display("FAIL partial_dirty d=%b exp 10 (or data vs model)",
                     rdata_dirty_o);
        end
    endtask

    task automatic test_same_cycle();
        int k;
        logic [LW-1:0] d;
        d = '0;
        d[15:0] = 16'hBEEF;
        drive_write(8'h10, 0, 19'h00123, 1'b1, 1'b0, d, 64'h3);
        model_write(8'h10, 0, 19'h00123, 1'b1, 1'b0, d, 64'h3);
        rden_i  = 1'b1;
        raddr_i = 8'h10;
        expect_set(8'h10);
        step();
        idle_in();
        checks++;
        if (rvalid_o !== 1'b1 || rdata_tag_o[TW-1:0] !== 19'h00123 ||
            rdata_data_o[15:0] !== 16'hBEEF) begin
            errors++;
            $display("FAIL rw_bypass rv=%b tag0=%h d0=%h exp 1 00123 beef",
                     rvalid_o, rdata_tag_o[TW-1:0], rdata_data_o[15:0]);
        end
        checks++;
        if ({rdata_tag_o, rdata_valid_o, rdata_dirty_o} !==
            {e_tag, e_val, e_dty} || rdata_data_o !== e_data) begin
            errors++;
            k = first_diff(rdata_data_o, e_data);
            $display("FAIL rw_model tag=%h v=%b chunk%0d got=%h exp=%h",
                     rdata_tag_o, rdata_valid_o, k,
                     rdata_data_o[64*k +: 64], e_data[64*k +: 64]);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        for (int c = 0; c < 300; c++) begin
            bit rd, wr, v, d;
            int rs, ws, w;
            logic [TW-1:0] t;
            logic [LW-1:0] dat;
            logic [BW-1:0] be;
            idle_in();
            rd  = 1'($urandom);
            wr  = 1'($urandom);
            rs  = 8'h40 + $urandom_range(0, 3);
            ws  = 8'h40 + $urandom_range(0, 3);
            w   = $urandom_range(0, NW - 1);
            t   = TW'($urandom);
            v   = 1'($urandom);
            d   = 1'($urandom);
            dat = rand_line();
            be  = {$urandom, $urandom};
            if (wr) begin
                drive_write(ws, w, t, v, d, dat, be);
                model_write(ws, w, t, v, d, dat, be);
            end
            if (rd) begin
                rden_i  = 1'b1;
                raddr_i = 8'(rs);
                expect_set(rs);
            end
            step();
            checks++;
            if (rvalid_o !== rd ||
                {rdata_tag_o, rdata_valid_o, rdata_dirty_o} !==
                {e_tag, e_val, e_dty} || rdata_data_o !== e_data) begin
                errors++;
                k = first_diff(rdata_data_o, e_data);
                $display("FAIL b2b c=%0d rv=%b/%b tag=%h/%h v=%b/%b d=%b/%b ch%0d %h/%h",
                         c, rvalid_o, rd, rdata_tag_o, e_tag,
                         rdata_valid_o, e_val, rdata_dirty_o, e_dty, k,
                         rdata_data_o[64*k +: 64], e_data[64*k +: 64]);
            end
        end
        idle_in();
    endtask

    task automatic test_reset_mid();
        int n;
        int k;
        rden_i  = 1'b1;
        raddr_i = 8'h41;
        step();
        rden_i = 1'b0;
        checks++;
        if (rvalid_o !== 1'b1) begin
            errors++;
            $display("FAIL pend_read rvalid=%b exp 1", rvalid_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rvalid_o !== 1'b0 || busy_o !== 1'b1 ||
            rdata_tag_o !== '0 || rdata_data_o !== '0) begin
            errors++;
            $display("FAIL rst_cancel rv=%b busy=%b tag=%h exp 0 1 0",
                     rvalid_o, busy_o, rdata_tag_o);
        end
        step();
        rst_n = 1'b1;
        repeat (100) step();
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL sweep_mid busy=%b exp 1", busy_o);
        end
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        n = 0;
        while (busy_o === 1'b1 && n < 1000) begin
            step();
            n++;
        end
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL rst_restart_len got %0d exp 256", n);
        end
        model_clear_vd();
        rden_i  = 1'b1;
        raddr_i = 8'h41;
        expect_set(8'h41);
        step();
        rden_i = 1'b0;
        checks++;
        if ({rvalid_o, rdata_tag_o, rdata_valid_o, rdata_dirty_o} !==
            {1'b1, e_tag, e_val, e_dty} || rdata_data_o !== e_data) begin
            errors++;
            k = first_diff(rdata_data_o, e_data);
            $display("FAIL retain tag=%h/%h v=%b d=%b ch%0d %h/%h",
                     rdata_tag_o, e_tag, rdata_valid_o, rdata_dirty_o,
                     k, rdata_data_o[64*k +: 64], e_data[64*k +: 64]);
        end
    endtask

    initial begin
        idle_in();
        rst_n = 1'b0;
        test_reset();
        test_fill();
        test_inv();
        test_write_read();
        test_partial();
        test_same_cycle();
        test_back_to_back();
        test_inv();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
